// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a synchronous FIFO into a valid/ready stream
// through a 2-entry buffer that hides the FIFO's one-cycle read latency.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  err_underflow
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              buf_cnt;
  logic [1:0]              buf_after_pop;
  logic [1:0]              buf_cnt_next;
  logic                    inflight;
  logic                    pop;
  logic [FIFO_WIDTH-1:0]   head;
  logic [FIFO_WIDTH-1:0]   tail;

  assign m_valid       = rst_n && (buf_cnt != 2'd0);
  assign pop           = m_valid && m_ready;
  assign m_data        = head;
  assign busy          = (state != IDLE);
  assign buf_after_pop = buf_cnt - {1'b0, pop};
  assign buf_cnt_next  = buf_after_pop + {1'b0, inflight};

  // Only read when the word returning next cycle is guaranteed a free slot.
  assign fifo_rd_en = rst_n && (state == RUN) && enable && !fifo_empty &&
                      (buf_cnt_next <= 2'd1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = STOP;
      STOP:    if (buf_cnt == 2'd0 && !inflight) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      buf_cnt       <= 2'd0;
      inflight      <= 1'b0;
      head          <= '0;
      tail          <= '0;
      xfer_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      buf_cnt  <= buf_cnt_next;
      if (pop && buf_cnt == 2'd2)
        head <= tail;
      // Returning word lands in the first slot still free after this cycle's pop.
      if (inflight) begin
        if (buf_after_pop == 2'd0)
          head <= fifo_data_out;
        else
          tail <= fifo_data_out;
      end
      if (pop)
        xfer_count <= xfer_count + 1'b1;
      if (fifo_underflow)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader with a
// queue-based model of the synchronous FIFO's registered read port.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_underflow = 1'b0;
  logic [15:0] fifo_data_out = 16'h0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        busy;
  logic [15:0] xfer_count;
  logic        err_underflow;

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .xfer_count(xfer_count),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  int cyc, rd_total, pop_total, first_rd, last_rd, first_pop, last_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; rd_total = 0; pop_total = 0;
    first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One cycle: settle, sample outputs mid-cycle, cross the edge, update the FIFO model.
  task automatic tick();
    logic rd, pp;
    #1;
    rd = fifo_rd_en;
    pp = m_valid && m_ready;
    if (rd) begin
      check("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      rd_total++;
    end
    if (pp) begin
      if (exp_q.size() == 0) check("extra_word", {16'd0, m_data}, 32'hFFFF_FFFF);
      else check("data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pop_total++;
    end
    @(posedge clk);
    #1;
    if (rd && fq.size() != 0) fifo_data_out = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
    tick(); tick();
    clr_stats();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    check("drain_timeout", {31'd0, (exp_q.size() != 0)}, 32'd0);
  endtask

  initial begin
    // Reset state, with a loaded FIFO and enable high to prove gating.
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    enable = 1'b1; m_ready = 1'b1;
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_xfer", {16'd0, xfer_count}, 32'd0);
    check("rst_err", {31'd0, err_underflow}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);

    // Test 1: streaming at full rate.
    rst_n = 1'b1;
    tick();
    drain(40);
    check("t1_rd_total", rd_total, 8);
    check("t1_rd_consec", last_rd - first_rd, 7);
    check("t1_pop_consec", last_pop - first_pop, 7);
    check("t1_latency", first_pop - first_rd, 2);
    check("t1_xfer", {16'd0, xfer_count}, 32'd8);
    check("t1_busy_run", {31'd0, busy}, 32'd1);
    #1;
    check("t1_rd_idle", {31'd0, fifo_rd_en}, 32'd0);

    // Test 2: full backpressure caps reads at two.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(16'h0100 + 16'(i));
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t2_rd_total", rd_total, 2);
    check("t2_m_valid", {31'd0, m_valid}, 32'd1);
    check("t2_hold_data", {16'd0, m_data}, 32'h0100);
    check("t2_fifo_left", fq.size(), 2);
    m_ready = 1'b1;
    drain(30);
    check("t2_xfer", {16'd0, xfer_count}, 32'd4);

    // Test 3: toggling ready.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'($urandom));
    rst_n = 1'b1; enable = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 80) begin m_ready = ~m_ready; tick(); n++; end
      check("t3_timeout", {31'd0, (exp_q.size() != 0)}, 32'd0);
    end
    check("t3_xfer", {16'd0, xfer_count}, 32'd8);

    // Test 4: stop after three pops; buffered and in-flight words still delivered.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'h0400 + 16'(i));
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    begin
      int n = 0;
      while (pop_total < 3 && n < 30) begin tick(); n++; end
      enable = 1'b0;
      n = 0;
      while (busy && n < 30) begin tick(); n++; end
      check("t4_busy_drop", {31'd0, busy}, 32'd0);
    end
    check("t4_pops", pop_total, 5);
    check("t4_fifo_left", fq.size(), 3);
    tick();
    check("t4_idle_no_rd", rd_total, 5);

    // Test 5: reset mid-burst with a full buffer, then sticky underflow.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'h0500 + 16'(i));
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t5_full", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t5_rst_rd", {31'd0, fifo_rd_en}, 32'd0);
    tick();
    rst_n = 1'b1;
    check("t5_m_valid", {31'd0, m_valid}, 32'd0);
    check("t5_xfer", {16'd0, xfer_count}, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    exp_q = fq;
    m_ready = 1'b1;
    drain(40);
    check("t5_xfer_after", {16'd0, xfer_count}, 32'd6);
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    check("t5_err_set", {31'd0, err_underflow}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("t5_err_hold", {31'd0, err_underflow}, 32'd1);
    do_reset();
    check("t5_err_clr", {31'd0, err_underflow}, 32'd0);

    // Test 6: counter wrap.
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    begin
      int n = 0;
      logic [15:0] w = 16'h0;
      while (pop_total < 65535 && n < 70000) begin
        if (fq.size() < 4) begin push_word(w); w++; end
        tick(); n++;
      end
      check("t6_xfer_ffff", {16'd0, xfer_count}, 32'h0000FFFF);
      while (pop_total < 65536 && n < 70000) begin
        if (fq.size() < 4) begin push_word(w); w++; end
        tick(); n++;
      end
      check("t6_xfer_wrap", {16'd0, xfer_count}, 32'h00000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
